// File: rtl/text_buffer.sv
// Character-cell frame buffer: byte-stream terminal writer (cursor, LF/CR/BS/FF) plus an 8x8-cell read port.
// Read latency 1 cycle; wr_ready is registered and drops while a full-screen or row clear is running.
module text_buffer #(
    parameter int         COLS     = 80,
    parameter int         ROWS     = 60,
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic       px_clk,
    input  logic       rst_n,
    input  logic [7:0] wr_char,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    output logic [7:0] character,
    output logic [6:0] cursor_col,
    output logic [5:0] cursor_row,
    output logic       busy
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [AW-1:0] COLS_A        = AW'(COLS);
    localparam logic [AW-1:0] LAST_CELL     = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_ROW_CELL = AW'(COLS - 1);
    localparam logic [6:0]    LAST_COL      = 7'(COLS - 1);
    localparam logic [5:0]    LAST_ROW      = 6'(ROWS - 1);

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [6:0]      col_q, col_d;
    logic [5:0]      row_q, row_d;
    logic            wr_ready_q;
    logic            busy_q;
    logic [7:0]      char_q;

    logic [7:0]      mem [CELLS];

    logic            accept;
    logic            advance;
    logic            we;
    logic [7:0]      wdat;
    logic [AW-1:0]   wr_addr;

    logic [6:0]      rd_col;
    logic [6:0]      rd_row;
    logic            rd_oob;
    logic [AW-1:0]   rd_addr;
    logic            unused_pos_lsb;

    assign accept = wr_valid && wr_ready_q;

    // Row clears use row_q, which already holds the newly entered row.
    always_comb begin
        wr_addr = AW'(row_q) * COLS_A + AW'(col_q);
        if (state_q == CLEAR_ALL) begin
            wr_addr = cnt_q;
        end else if (state_q == CLEAR_ROW) begin
            wr_addr = AW'(row_q) * COLS_A + cnt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        we      = 1'b0;
        wdat    = CLR_CHAR;
        advance = 1'b0;
        case (state_q)
            CLEAR_ALL: begin
                we    = 1'b1;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_CELL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            CLEAR_ROW: begin
                we    = 1'b1;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_ROW_CELL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (accept) begin
                    case (wr_char)
                        8'h0A: begin
                            col_d   = '0;
                            advance = 1'b1;
                        end
                        8'h0D: col_d = '0;
                        8'h08: begin
                            if (col_q != '0) begin
                                col_d = col_q - 7'd1;
                            end
                        end
                        8'h0C: begin
                            col_d   = '0;
                            row_d   = '0;
                            cnt_d   = '0;
                            state_d = CLEAR_ALL;
                        end
                        default: begin
                            we   = 1'b1;
                            wdat = wr_char;
                            if (col_q == LAST_COL) begin
                                col_d   = '0;
                                advance = 1'b1;
                            end else begin
                                col_d = col_q + 7'd1;
                            end
                        end
                    endcase
                end
                // Wrap to the top instead of scrolling; the entered row is blanked.
                if (advance) begin
                    row_d   = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
                    cnt_d   = '0;
                    state_d = CLEAR_ROW;
                end
            end
            default: begin
                state_d = CLEAR_ALL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR_ALL;
            cnt_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wr_ready_q <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
        end
    end

    always_ff @(posedge px_clk) begin
        if (we && rst_n) begin
            mem[wr_addr] <= wdat;
        end
    end

    assign rd_col         = pos_x[9:3];
    assign rd_row         = pos_y[9:3];
    assign rd_oob         = (int'(rd_col) >= COLS) || (int'(rd_row) >= ROWS);
    assign rd_addr        = AW'(rd_row) * COLS_A + AW'(rd_col);
    assign unused_pos_lsb = ^{pos_x[2:0], pos_y[2:0]};

    // Same-cell read and write on one edge returns the old contents.
    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            char_q <= CLR_CHAR;
        end else begin
            char_q <= rd_oob ? CLR_CHAR : mem[rd_addr];
        end
    end

    assign wr_ready   = wr_ready_q;
    assign busy       = busy_q;
    assign character  = char_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: directed terminal scenarios plus a random byte stream against a cell-array model.
module tb_text_buffer;
    localparam int NC    = 80;
    localparam int NR    = 60;
    localparam int CELLS = NC * NR;

    logic       px_clk;
    logic       rst_n;
    logic [7:0] wr_char;
    logic       wr_valid;
    logic       wr_ready;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [7:0] character;
    logic [6:0] cursor_col;
    logic [5:0] cursor_row;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [CELLS];
    int m_col, m_row;

    text_buffer dut (
        .px_clk     (px_clk),
        .rst_n      (rst_n),
        .wr_char    (wr_char),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .character  (character),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    function automatic logic [7:0] model_char(input int x, input int y);
        int cx, cy;
        cx = x / 8;
        cy = y / 8;
        if (cx >= NC || cy >= NR) return 8'h20;
        return mem_m[cy * NC + cx];
    endfunction

    task automatic model_clear_all();
        for (int i = 0; i < CELLS; i++) mem_m[i] = 8'h20;
    endtask

    // Returns how many cycles the writer stays not-ready after this byte.
    task automatic model_apply(input logic [7:0] b, output int clr);
        bit adv;
        clr = 0;
        adv = 0;
        if (b == 8'h0A) begin
            m_col = 0;
            adv = 1;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            model_clear_all();
            clr = CELLS;
        end else begin
            mem_m[m_row * NC + m_col] = b;
            if (m_col == NC - 1) begin
                m_col = 0;
                adv = 1;
            end else begin
                m_col++;
            end
        end
        if (adv) begin
            m_row = (m_row + 1) % NR;
            for (int c = 0; c < NC; c++) mem_m[m_row * NC + c] = 8'h20;
            clr = NC;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!wr_ready && n < 10000) begin
            step();
            n++;
        end
        check(tag, wr_ready, 1);
    endtask

    task automatic send(input logic [7:0] b);
        int clr, n;
        wait_ready("send_rdy");
        wr_char  = b;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        model_apply(b, clr);
        check("cur_col", cursor_col, m_col);
        check("cur_row", cursor_row, m_row);
        if (clr > 0) begin
            check("rdy_drop", wr_ready, 0);
            n = 0;
            while (!wr_ready && n < clr + 100) begin
                step();
                n++;
            end
            check("clr_len", n, clr);
        end else begin
            check("rdy_hold", wr_ready, 1);
        end
    endtask

    task automatic rd(input string tag, input int x, input int y, input logic [7:0] exp);
        pos_x = 10'(x);
        pos_y = 10'(y);
        step();
        check(tag, character, exp);
    endtask

    task automatic scan(input string tag);
        int x, y;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                x = c * 8 + int'($urandom_range(0, 7));
                y = r * 8 + int'($urandom_range(0, 7));
                rd(tag, x, y, model_char(x, y));
            end
        end
    endtask

    function automatic logic [7:0] printable();
        return 8'(8'h21 + $urandom_range(0, 93));
    endfunction

    initial begin
        int n, busy_bad, clr, accepted, mw;
        logic [7:0] old, b;
        bit rdy_before;

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_char  = 8'h00;
        pos_x    = '0;
        pos_y    = '0;
        m_col    = 0;
        m_row    = 0;
        step();
        step();
        check("rst_busy", busy, 1);
        check("rst_rdy", wr_ready, 0);
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);
        check("rst_char", character, 8'h20);

        // Power-up clear
        rst_n = 1'b1;
        n = 0;
        busy_bad = 0;
        while (!wr_ready && n < 10000) begin
            if (busy !== 1'b1) busy_bad++;
            step();
            n++;
        end
        check("init_clear_len", n, CELLS);
        check("init_busy_held", busy_bad, 0);
        check("init_busy_done", busy, 0);
        model_clear_all();
        scan("init_scan");

        // "AB" and basic reads
        send(8'h41);
        send(8'h42);
        check("ab_col", cursor_col, 2);
        check("ab_row", cursor_row, 0);
        rd("rd_0_0", 0, 0, 8'h41);
        rd("rd_8_7", 8, 7, 8'h42);
        rd("rd_16_0", 16, 0, 8'h20);

        // Write and read the same cell on the same edge
        pos_x    = 10'd16;
        pos_y    = 10'd0;
        wr_char  = 8'h43;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        model_apply(8'h43, clr);
        check("rbw_old", character, 8'h20);
        step();
        check("rbw_new", character, 8'h43);

        // Full line from home wraps to row 1 and blanks it
        send(8'h0D);
        for (int i = 0; i < NC; i++) send(printable());
        check("line_col", cursor_col, 0);
        check("line_row", cursor_row, 1);
        for (int c = 0; c < NC; c++) rd("row1_blank", c * 8, 8, 8'h20);
        for (int c = 0; c < NC; c += 7) rd("row0_kept", c * 8 + 3, 5, model_char(c * 8, 0));

        // Walk down to row 59 leaving content on every row
        for (int r = 1; r < NR - 1; r++) begin
            for (int k = 0; k < 3; k++) send(printable());
            send(8'h0A);
        end
        for (int k = 0; k < 5; k++) send(printable());
        check("r59_col", cursor_col, 5);
        check("r59_row", cursor_row, 59);
        send(8'h0A);
        check("wrap_col", cursor_col, 0);
        check("wrap_row", cursor_row, 0);
        scan("wrap_scan");

        // CR and BS
        for (int k = 0; k < 3; k++) send(printable());
        send(8'h0D);
        check("cr_col", cursor_col, 0);
        check("cr_busy", busy, 0);
        send(8'h08);
        check("bs0_col", cursor_col, 0);
        check("bs0_row", cursor_row, 0);
        send(8'h51);
        send(8'h52);
        send(8'h08);
        check("bs_col", cursor_col, 1);
        rd("bs_no_erase", 8, 0, 8'h52);

        // Form feed, reads during the clear, reset at clear count 1000
        send(8'h61);
        old = model_char(0, 59 * 8);
        wait_ready("ff_rdy");
        wr_char  = 8'h0C;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        model_apply(8'h0C, clr);
        check("ff_col", cursor_col, 0);
        check("ff_row", cursor_row, 0);
        check("ff_rdy_drop", wr_ready, 0);
        check("ff_busy", busy, 1);
        rd("ff_read_during", 0, 59 * 8, old);
        repeat (999) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("ffrst_busy", busy, 1);
        check("ffrst_rdy", wr_ready, 0);
        n = 0;
        while (!wr_ready && n < 10000) begin
            step();
            n++;
        end
        check("ffrst_clear_len", n, CELLS);
        m_col = 0;
        m_row = 0;
        scan("ff_scan");

        // Off-screen reads
        send(8'h58);
        send(8'h0A);
        send(8'h59);
        rd("oob_x640", 640, 0, 8'h20);
        rd("oob_y480", 0, 480, 8'h20);
        rd("oob_max", 1023, 1023, 8'h20);
        rd("oob_inrange", 0, 8, 8'h59);

        // Continuous random stream
        wait_ready("rnd_start");
        accepted = 0;
        mw = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 4) b = 8'h0A;
            else if (n < 7) b = 8'h0D;
            else if (n < 10) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h0C) b = 8'h5A;
            end
            wr_char = b;
            rdy_before = wr_ready;
            check("rnd_rdy", wr_ready, (mw == 0) ? 1 : 0);
            step();
            if (rdy_before) begin
                model_apply(b, clr);
                accepted++;
                mw = clr;
            end else if (mw > 0) begin
                mw--;
            end
            check("rnd_col", cursor_col, m_col);
            check("rnd_row", cursor_row, m_row);
        end
        wr_valid = 1'b0;
        check("rnd_some_accepted", (accepted > 100) ? 1 : 0, 1);
        wait_ready("rnd_end");
        scan("rnd_scan");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Character-cell frame buffer that produces the `character` stream consumed by the font pixel lookup.
- Write side: a byte-stream terminal interface with a valid/ready handshake, a cursor and control-code handling.
- Read side: maps the current pixel position to the 8x8 cell holding it, with one registered cycle of latency.
- Sits between the CPU/UART byte source and the font lookup in the VGA text pipeline.

Parameters:
- COLS, 80, number of text columns (8 px each).
- ROWS, 60, number of text rows (8 px each).
- CLR_CHAR, 8'h20, fill value used for clears and for off-screen reads.

Ports:
- px_clk  in  1  pixel clock; only clock in the block.
- rst_n  in  1  reset, synchronous, active-low.
- wr_char  in  8  byte to write or control code.
- wr_valid  in  1  wr_char is valid.
- wr_ready  out  1  block can accept a byte this cycle.
- pos_x  in  10  X screen position.
- pos_y  in  10  Y screen position.
- character  out  8  character code at (pos_x, pos_y), registered.
- cursor_col  out  7  current cursor column, 0..COLS-1.
- cursor_row  out  6  current cursor row, 0..ROWS-1.
- busy  out  1  clear in progress.

Behaviour:
- Storage: COLS*ROWS x 8 RAM, single write port, single read port.
  - Cell address = row*COLS + col.
  - Address width = clog2(COLS*ROWS), which is 13 at the defaults.
- Reset (rst_n=0 sampled on a px_clk edge):
  - cursor_col=0, cursor_row=0, wr_ready=0, busy=1, character=CLR_CHAR.
  - The FSM goes to CLEAR_ALL with the clear counter at 0.
  - Reset asserted during any clear restarts the clear from cell 0.
- FSM states: CLEAR_ALL, IDLE, CLEAR_ROW.
  - CLEAR_ALL: writes CLR_CHAR to one cell per cycle, addresses 0..COLS*ROWS-1. Takes exactly COLS*ROWS cycles, then goes to IDLE. wr_ready=0, busy=1.
  - IDLE: wr_ready=1, busy=0. A byte is accepted on a cycle where wr_valid=1 and wr_ready=1.
  - CLEAR_ROW: writes CLR_CHAR to cells (cursor_row, 0..COLS-1), one per cycle, then goes to IDLE. Takes COLS cycles. wr_ready=0, busy=1.
- Accepted byte handling in IDLE, with the effect visible on the following cycle:
  - 8'h0A (LF): col=0, row advances.
  - 8'h0D (CR): col=0; row unchanged.
  - 8'h08 (BS): if col>0 then col=col-1; no cell is erased. At col=0, no change.
  - 8'h0C (FF): col=0, row=0, go to CLEAR_ALL.
  - Any other value, including other codes below 8'h20: written to cell (row, col), then col=col+1. If col was COLS-1, col=0 and row advances.
- Row advance:
  - If row<ROWS-1 then row=row+1. Otherwise row=0 (wrap-around, no scrolling).
  - After any row advance, the FSM goes to CLEAR_ROW for the new row, so the new line starts blank.
- wr_ready is registered, combinationally independent of wr_valid, and deasserts in the cycle after an accepting byte that triggers a clear. No byte is ever dropped or double-written.
- Read path:
  - The cell is (pos_y[9:3], pos_x[9:3]).
  - character <= RAM[cell] on each px_clk edge, a latency of 1 cycle.
  - The font lookup adds 1 more cycle, so a pixel appears 2 cycles after pos; the timing generator compensates.
  - If pos_x[9:3] >= COLS or pos_y[9:3] >= ROWS, character <= CLR_CHAR.
- Read and write are fully independent; reads continue during clears.
- Simultaneous read and write to the same cell: read returns the old contents (read-before-write).
- The write is never blocked by the display.

Test Plan:
- Reset, then hold wr_valid=0 -> busy=1 and wr_ready=0 for exactly 4800 cycles. Then busy=0, wr_ready=1. Every cell reads 8'h20 via pos scan.
- Write "AB" (8'h41, 8'h42) -> cursor (col 2, row 0). pos=(0,0) gives character 8'h41 one cycle later. pos=(8,7) gives 8'h42. pos=(16,0) gives 8'h20.
- Write 80 printable bytes from home -> cursor (col 0, row 1). wr_ready=0 for 80 cycles during CLEAR_ROW, after which row 1 reads all 8'h20.
- From cursor (col 5, row 59), send 8'h0A -> cursor (col 0, row 0). Row 0 is cleared over 80 cycles while rows 1..59 are unchanged. Send 8'h0D at col 3 -> col 0, no clear. Send 8'h08 at col 0 -> no change.
- Send 8'h0C mid-screen -> cursor (0,0) and a 4800-cycle clear. Assert rst_n=0 for 1 cycle at clear count 1000 -> the clear restarts and completes 4800 cycles after reset release.
- pos_x=640 or pos_y=480 -> character 8'h20. Drive wr_valid continuously with random bytes -> the number of accepted handshakes matches the cursor advance, and the bytes are not reordered.
